// File: rtl/alu_pkg.sv
// alu_pkg: shared width defaults, ALU control codes, opcode and FSM state types
package alu_pkg;
    localparam int DATA_SIZE_DEF = 32;
    localparam int CTRL_SIZE_DEF = 1;
    localparam logic ALU_ADD  = 1'b1;
    localparam logic ALU_ZERO = 1'b0;
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDI = 2'b01,
        OP_BNE  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;
endpackage

// File: rtl/reg_file.sv
// reg_file: register array with two combinational read ports, one synchronous write port,
// register 0 hardwired to zero and a live tap of register 10
module reg_file #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [ADDR_SIZE-1:0] i_raddr1,
    input  logic [ADDR_SIZE-1:0] i_raddr2,
    output logic [DATA_SIZE-1:0] o_rdata1,
    output logic [DATA_SIZE-1:0] o_rdata2,
    output logic [DATA_SIZE-1:0] o_a0
);
    localparam int NREGS = 1 << ADDR_SIZE;
    logic [DATA_SIZE-1:0] r_regs [NREGS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end
    assign o_rdata1 = i_raddr1 == '0 ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = i_raddr2 == '0 ? '0 : r_regs[i_raddr2];
    assign o_a0     = r_regs[10];
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: one-instruction-in-flight sequencer feeding an external ALU
// (IDLE -> EXEC -> WB), with register file, pc and branch handling
module alu_issue_seq import alu_pkg::*; #(
    parameter int DATA_SIZE = alu_pkg::DATA_SIZE_DEF,
    parameter int CTRL_SIZE = alu_pkg::CTRL_SIZE_DEF,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [1:0]           instr_op,
    input  logic [ADDR_SIZE-1:0] instr_rs1,
    input  logic [ADDR_SIZE-1:0] instr_rs2,
    input  logic [ADDR_SIZE-1:0] instr_rd,
    input  logic [DATA_SIZE-1:0] instr_imm,
    output logic [DATA_SIZE-1:0] ALUop1,
    output logic [DATA_SIZE-1:0] ALUop2,
    output logic [CTRL_SIZE-1:0] ALUctrl,
    input  logic [DATA_SIZE-1:0] ALUout,
    input  logic                 EQ,
    output logic [DATA_SIZE-1:0] pc,
    output logic                 branch_taken,
    output logic [DATA_SIZE-1:0] a0
);
    state_e                 r_state, w_next;
    op_e                    r_op, w_op;
    logic [ADDR_SIZE-1:0]   r_rd;
    logic [DATA_SIZE-1:0]   r_imm, r_result, w_rs1_val, w_rs2_val;
    logic                   r_eq, w_accept, w_we, w_taken;

    assign w_op        = op_e'(instr_op);
    assign instr_ready = r_state == S_IDLE;
    assign w_accept    = instr_valid && instr_ready;
    assign w_we        = r_state == S_WB && r_op != OP_BNE;
    assign w_taken     = r_state == S_WB && r_op == OP_BNE && !r_eq;

    reg_file #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (r_rd),
        .i_wdata  (r_result),
        .i_raddr1 (instr_rs1),
        .i_raddr2 (instr_rs2),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val),
        .o_a0     (a0)
    );

    always_comb begin
        w_next = S_IDLE;
        w_next = r_state == S_IDLE ? (w_accept ? S_EXEC : S_IDLE) :
                 r_state == S_EXEC ? S_WB : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Operands are latched at accept and held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_ADD;
            r_rd         <= '0;
            r_imm        <= '0;
            r_result     <= '0;
            r_eq         <= 1'b0;
            ALUop1       <= '0;
            ALUop2       <= '0;
            ALUctrl      <= '0;
            pc           <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_rd    <= instr_rd;
                r_imm   <= instr_imm;
                ALUop1  <= w_rs1_val;
                ALUop2  <= (w_op == OP_ADD || w_op == OP_BNE) ? w_rs2_val : instr_imm;
                ALUctrl <= CTRL_SIZE'((w_op == OP_ADD || w_op == OP_ADDI) ? ALU_ADD : ALU_ZERO);
            end
            if (r_state == S_EXEC) begin
                r_result <= ALUout;
                r_eq     <= EQ;
            end
            if (r_state == S_WB) pc <= pc + (w_taken ? r_imm : DATA_SIZE'(4));
            branch_taken <= w_taken;
        end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench with an architectural reference model and a behavioural ALU
module tb_alu_issue_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_op = 2'b00;
    logic [4:0]  instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
    logic [31:0] instr_imm = '0;
    logic [31:0] ALUop1, ALUop2, ALUout, pc, a0;
    logic [0:0]  ALUctrl;
    logic        EQ, branch_taken;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
        .instr_imm(instr_imm), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .ALUout(ALUout), .EQ(EQ), .pc(pc), .branch_taken(branch_taken), .a0(a0)
    );

    // external combinational ALU
    assign ALUout = ALUctrl[0] ? ALUop1 + ALUop2 : 32'd0;
    assign EQ     = ALUop1 == ALUop2;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        ctrl;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] a0;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          errors = 0, checks = 0, cyc = 0, last_acc = 0;
    bit          chain = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0;
    endtask

    function automatic logic [31:0] rv(input logic [4:0] idx);
        return idx == 0 ? 32'd0 : m_regs[idx];
    endfunction

    task automatic issue(input op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input bit keep);
        exp_t        e;
        logic [31:0] a, b, val;
        int          n;
        @(negedge clk);
        instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", {31'd0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        a = rv(rs1);
        b = rv(rs2);
        e.op1   = a;
        e.op2   = (op == OP_ADD || op == OP_BNE) ? b : imm;
        e.ctrl  = op == OP_ADD || op == OP_ADDI;
        e.taken = op == OP_BNE && a != b;
        val = op == OP_ADD ? a + b : op == OP_ADDI ? a + imm : 32'd0;
        if (op != OP_BNE && rd != 0) m_regs[rd] = val;
        m_pc = m_pc + (e.taken ? imm : 32'd4);
        e.pc = m_pc;
        e.a0 = m_regs[10];
        q.push_back(e);
        @(posedge clk);
        #1;
        if (chain) chk("accept_spacing", cyc - last_acc, 3);
        chain = keep;
        last_acc = cyc;
        if (keep) begin
            instr_op = 2'($urandom); instr_rs1 = 5'($urandom); instr_rs2 = 5'($urandom);
            instr_rd = 5'($urandom); instr_imm = $urandom;
        end else begin
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // monitor: EXEC cycle shows the operands, return to IDLE shows the architectural result
    initial begin
        bit   prev = 1'b1, fall, rise;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                fall = prev && !instr_ready;
                rise = !prev && instr_ready;
                if (fall) begin
                    if (q.size() == 0) chk("exec_without_issue", 32'd1, 32'd0);
                    else begin
                        chk("ALUop1", ALUop1, q[0].op1);
                        chk("ALUop2", ALUop2, q[0].op2);
                        chk("ALUctrl", {31'd0, ALUctrl}, {31'd0, q[0].ctrl});
                    end
                end
                chk("branch_taken", {31'd0, branch_taken},
                    {31'd0, rise && q.size() != 0 && q[0].taken});
                if (rise) begin
                    if (q.size() == 0) chk("retire_without_issue", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("pc", pc, e.pc);
                        chk("a0", a0, e.a0);
                    end
                end
            end
            prev = instr_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_a0", a0, 0);
        chk("rst_ready", {31'd0, instr_ready}, 1);
        chk("rst_op1", ALUop1, 0);
        chk("rst_op2", ALUop2, 0);
        chk("rst_ctrl", {31'd0, ALUctrl}, 0);
        chk("rst_bt", {31'd0, branch_taken}, 0);
        #5 rst_n = 1'b1;

        issue(OP_ADDI, 0, 0, 10, 32'd5, 0);
        wait_drain();
        chk("addi_a0", a0, 32'd5);
        chk("addi_pc", pc, 32'd4);

        do_reset();
        issue(OP_ADDI, 0, 0, 1, 32'd7, 0);
        issue(OP_ADDI, 0, 0, 2, 32'd7, 0);
        issue(OP_BNE, 1, 2, 0, 32'd16, 0);
        wait_drain();
        chk("bne_eq_pc", pc, 32'd12);

        do_reset();
        issue(OP_ADDI, 0, 0, 1, 32'd7, 0);
        issue(OP_ADDI, 0, 0, 2, 32'd9, 0);
        issue(OP_BNE, 1, 2, 0, 32'hFFFF_FFF8, 0);
        wait_drain();
        chk("bne_taken_pc", pc, 32'd0);

        issue(OP_ADDI, 0, 0, 0, 32'd3, 0);
        issue(OP_ADD, 0, 0, 5, 32'd0, 0);
        issue(OP_ADDI, 0, 0, 10, 32'd5, 0);
        issue(OP_CLR, 10, 10, 10, 32'd77, 0);
        issue(OP_ADDI, 0, 0, 1, 32'hFFFF_FFFF, 0);
        issue(OP_ADDI, 0, 0, 2, 32'd1, 0);
        issue(OP_ADD, 1, 2, 3, 32'd0, 0);
        issue(OP_ADD, 3, 3, 10, 32'd0, 0);
        wait_drain();
        chk("clr_then_wrap_a0", a0, 32'd0);

        issue(OP_ADDI, 0, 0, 10, 32'd9, 0);
        issue(OP_ADDI, 0, 0, 10, 32'd5, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("wbrst_a0", a0, 0);
        chk("wbrst_pc", pc, 0);
        chk("wbrst_ready", {31'd0, instr_ready}, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("wbrst_a0_after", a0, 0);
        chk("wbrst_pc_after", pc, 0);
        chk("wbrst_ready_after", {31'd0, instr_ready}, 1);

        for (int i = 0; i < 60; i++) begin
            issue(op_e'($urandom_range(0, 3)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                  $urandom_range(0, 3) == 0 ? 5'd10 : 5'($urandom_range(0, 11)), $urandom, i != 59);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning operand/result/register width.
REQ-002 SHALL have parameter CTRL_SIZE, default 1, meaning ALU control width.
REQ-003 SHALL have parameter ADDR_SIZE, default 5, meaning register index width (32 registers).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr_ready  output  1  sequencer can accept an instruction.
REQ-008 instr_op  input  2  00 ADD, 01 ADDI, 10 BNE, 11 CLR.
REQ-009 instr_rs1, instr_rs2, instr_rd  input  ADDR_SIZE each  source and destination indices.
REQ-010 instr_imm  input  DATA_SIZE  immediate / branch offset.
REQ-011 ALUop1, ALUop2  output  DATA_SIZE each  operands to the external combinational ALU.
REQ-012 ALUctrl  output  CTRL_SIZE  1 = add, 0 = zero result.
REQ-013 ALUout  input  DATA_SIZE  ALU result; EQ  input  1  ALU equality flag.
REQ-014 pc  output  DATA_SIZE  program counter; branch_taken  output  1  one-cycle pulse; a0  output  DATA_SIZE  live value of register 10.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = 1 only in IDLE.
REQ-016 Accept = instr_valid && instr_ready at a rising edge; instruction fields latched; FSM -> EXEC.
REQ-017 At accept SHALL register ALUop1 = reg[rs1]; ALUop2 = reg[rs2] for ADD/BNE, instr_imm for ADDI/CLR; ALUctrl = 1 for ADD/ADDI, 0 for BNE/CLR.
REQ-018 ALUop1/ALUop2/ALUctrl SHALL be registered and hold value outside EXEC.
REQ-019 End of EXEC SHALL capture ALUout and EQ into internal result/flag registers; FSM -> WB.
REQ-020 End of WB: ADD/ADDI/CLR write result to reg[rd]; BNE writes nothing; FSM -> IDLE.
REQ-021 Writes to register 0 SHALL be discarded; reads of register 0 SHALL return 0.
REQ-022 End of WB: pc <= pc + imm if BNE and captured EQ = 0, else pc <= pc + 4; addition modulo 2^DATA_SIZE (wraps).
REQ-023 branch_taken SHALL be 1 for exactly the cycle after a taken-BNE WB, else 0.
REQ-024 Latency: accept at edge N, register write and pc update at edge N+2, instr_ready high again after edge N+2; max one instruction per 3 cycles.
REQ-025 instr_valid while not ready SHALL be ignored; instruction fields need only be stable at the accepting edge.
REQ-026 Source equal to destination of the previous instruction SHALL read the already-written value (no hazard possible; one instruction in flight).

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, pc 0, all registers 0, ALUop1/ALUop2 0, ALUctrl 0, branch_taken 0, result/flag 0.
REQ-028 Reset during EXEC or WB SHALL abort the instruction with no register or pc update.
REQ-029 First accept possible at the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg SHALL hold DATA_SIZE/CTRL_SIZE defaults, ALU_ADD = 1 / ALU_ZERO = 0 constants, the opcode enum, and the FSM state enum.
REQ-031 Register array SHALL be a sub-module reg_file: two combinational read ports, one synchronous write port, register 0 hardwired zero, a0 tap of register 10.
REQ-032 ALU SHALL stay external; this block contains no adder apart from the pc increment.

Verification
REQ-033 Reset, then ADDI rd=10 rs1=0 imm=5 -> a0 = 5 two edges after accept, pc = 4, ALUctrl = 1 in EXEC.
REQ-034 ADDI x1=7, ADDI x2=7, BNE rs1=1 rs2=2 imm=16 -> EQ = 1, not taken, pc = 12, branch_taken stays 0.
REQ-035 x1=7, x2=9, BNE imm=0xFFFFFFF8 at pc=8 -> taken, pc = 0, branch_taken high one cycle.
REQ-036 ADDI rd=0 imm=3 -> reg 0 reads 0; CLR rd=10 after a0=5 -> a0 = 0; ADD x3=x1+x2 with 0xFFFFFFFF+1 -> x3 = 0.
REQ-037 instr_valid held high continuously -> accepts exactly every third cycle, instr_ready low in EXEC/WB.
REQ-038 rst_n pulsed low during WB of ADDI a0=5 -> a0 = 0, pc = 0, state IDLE, instr_ready = 1 after deassertion.
